// File: rtl/wb_burst_master_if.sv
// Bundles the command, write-data, read-data, response and Wishbone signals of
// wb_burst_master.
//   master : the view used by wb_burst_master. It takes cmd/wr/slave responses
//            in and drives cmd_ready, wr_ready, rd_*, resp_* and wb_*_o out.
//   slave  : the opposite view, used by the sequencer and interconnect side.
interface wb_burst_master_if #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 16
);
  localparam int LW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_adr;
  logic          cmd_we;
  logic [DW/8-1:0] cmd_sel;
  logic [LW-1:0] cmd_len;

  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;

  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;

  logic          resp_valid;
  logic [1:0]    resp_status;

  logic [AW-1:0] wb_adr_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;
  logic          wb_rty_i;

  modport master (
    input  cmd_valid, cmd_adr, cmd_we, cmd_sel, cmd_len,
    input  wr_valid, wr_data,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
    output resp_valid, resp_status,
    output wb_adr_o, wb_sel_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_cti_o, wb_bte_o
  );

  modport slave (
    output cmd_valid, cmd_adr, cmd_we, cmd_sel, cmd_len,
    output wr_valid, wr_data,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
    input  resp_valid, resp_status,
    input  wb_adr_o, wb_sel_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_cti_o, wb_bte_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone B3 burst master driven by a command stream.
// A command (address, direction, byte lanes, beat count - 1) becomes one
// classic cycle (cti 000) or an incrementing burst (cti 010 ... 111).
// Write beats come from the wr_* stream, read beats leave on rd_*, and each
// command ends with a one-cycle resp_valid carrying its status:
// 00 ok, 01 bus error, 10 timeout, 11 retries exhausted.
// Ports:
//   wb_clk, wb_rst : clock, asynchronous active-high reset
//   bus            : wb_burst_master_if.master (cmd/wr/rd/resp streams and the
//                    Wishbone master port; all wb_*_o are flops)
module wb_burst_master #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 1024,
  parameter int RETRY_MAX = 3
) (
  input logic wb_clk,
  input logic wb_rst,
  wb_burst_master_if.master bus
);
  localparam int SW  = DW / 8;
  localparam int LW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;
  localparam logic [1:0] ST_RTY = 2'b11;

  typedef enum logic [2:0] {IDLE, BUS, STALL, RETRY, DRAIN, RESP} state_t;

  state_t        state, state_n;
  logic [LW-1:0] beat, beat_n, len, len_n;
  logic          we, we_n;
  logic [SW-1:0] sel, sel_n;
  logic [AW-1:0] adr, adr_n;
  logic [DW-1:0] dat, dat_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic [1:0]    status, status_n;
  logic [DW-1:0] rd_dat, rd_dat_n;
  logic          rd_vld_n, rd_last_n;
  logic          wr_rdy, abort, last;

  logic          cyc, stb, we_o, rd_vld, rd_last, resp, cmd_rdy;
  logic [2:0]    cti;

  assign last = (beat == len);

  always_comb begin
    state_n   = state;
    beat_n    = beat;
    len_n     = len;
    we_n      = we;
    sel_n     = sel;
    adr_n     = adr;
    dat_n     = dat;
    rcnt_n    = rcnt;
    tmo_n     = tmo;
    status_n  = status;
    rd_dat_n  = rd_dat;
    rd_vld_n  = 1'b0;
    rd_last_n = 1'b0;
    wr_rdy    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (bus.cmd_valid && cmd_rdy) begin
        len_n    = bus.cmd_len;
        we_n     = bus.cmd_we;
        sel_n    = bus.cmd_sel;
        adr_n    = bus.cmd_adr;
        beat_n   = '0;
        rcnt_n   = '0;
        tmo_n    = '0;
        status_n = ST_OK;
        if (!bus.cmd_we) state_n = BUS;
        else if (bus.wr_valid) begin
          wr_rdy  = 1'b1;
          dat_n   = bus.wr_data;
          state_n = BUS;
        end else state_n = STALL;
      end
      // Cycle is held open (cyc=1, stb=0) until the next write beat shows up.
      STALL: if (bus.wr_valid) begin
        wr_rdy  = 1'b1;
        dat_n   = bus.wr_data;
        state_n = BUS;
      end
      RETRY: state_n = BUS;
      BUS: begin
        // err beats rty beats ack when the slave raises several at once.
        if (bus.wb_err_i) begin
          abort    = 1'b1;
          status_n = ST_ERR;
        end else if (bus.wb_rty_i) begin
          tmo_n = '0;
          if (rcnt == RW'(RETRY_MAX)) begin
            abort    = 1'b1;
            status_n = ST_RTY;
          end else begin
            rcnt_n  = rcnt + 1'b1;
            state_n = RETRY;
          end
        end else if (bus.wb_ack_i) begin
          tmo_n  = '0;
          rcnt_n = '0;
          if (!we) begin
            rd_vld_n  = 1'b1;
            rd_dat_n  = bus.wb_dat_i;
            rd_last_n = last;
          end
          if (last) state_n = RESP;
          else begin
            beat_n = beat + 1'b1;
            adr_n  = adr + AW'(SW);
            if (we) begin
              if (bus.wr_valid) begin
                wr_rdy = 1'b1;
                dat_n  = bus.wr_data;
              end else state_n = STALL;
            end
          end
        end else begin
          tmo_n = tmo + 1'b1;
          if (TIMEOUT != 0 && tmo_n == TW'(TIMEOUT)) begin
            abort    = 1'b1;
            status_n = ST_TMO;
          end
        end
        // An aborted write still owes the stream its unsent beats.
        if (abort) state_n = (we && !last) ? DRAIN : RESP;
      end
      // beat tracks the last write beat taken off the stream.
      DRAIN: begin
        wr_rdy = 1'b1;
        if (bus.wr_valid) begin
          beat_n = beat + 1'b1;
          if (beat_n == len) state_n = RESP;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state   <= IDLE;
      beat    <= '0;
      len     <= '0;
      we      <= 1'b0;
      sel     <= '0;
      adr     <= '0;
      dat     <= '0;
      rcnt    <= '0;
      tmo     <= '0;
      status  <= '0;
      rd_dat  <= '0;
      rd_vld  <= 1'b0;
      rd_last <= 1'b0;
      cyc     <= 1'b0;
      stb     <= 1'b0;
      we_o    <= 1'b0;
      cti     <= '0;
      resp    <= 1'b0;
      cmd_rdy <= 1'b0;
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      len     <= len_n;
      we      <= we_n;
      sel     <= sel_n;
      adr     <= adr_n;
      dat     <= dat_n;
      rcnt    <= rcnt_n;
      tmo     <= tmo_n;
      status  <= status_n;
      rd_dat  <= rd_dat_n;
      rd_vld  <= rd_vld_n;
      rd_last <= rd_last_n;
      cyc     <= (state_n == BUS) || (state_n == STALL);
      stb     <= (state_n == BUS);
      we_o    <= we_n && ((state_n == BUS) || (state_n == STALL));
      cti     <= (len_n == '0) ? 3'b000 : (beat_n == len_n) ? 3'b111 : 3'b010;
      resp    <= (state_n == RESP);
      cmd_rdy <= (state_n == IDLE);
    end
  end

  assign bus.cmd_ready   = cmd_rdy;
  assign bus.wr_ready    = wr_rdy;
  assign bus.rd_valid    = rd_vld;
  assign bus.rd_data     = rd_dat;
  assign bus.rd_last     = rd_last;
  assign bus.resp_valid  = resp;
  assign bus.resp_status = status;
  assign bus.wb_adr_o    = adr;
  assign bus.wb_sel_o    = sel;
  assign bus.wb_dat_o    = dat;
  assign bus.wb_we_o     = we_o;
  assign bus.wb_cyc_o    = cyc;
  assign bus.wb_stb_o    = stb;
  assign bus.wb_cti_o    = cti;
  assign bus.wb_bte_o    = 2'b00;
endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: combinational Wishbone slave with
// per-beat err/rty injection, a write-data feeder with an optional gap, and a
// negedge monitor that logs bus activity per command.
module tb_wb_burst_master;
  localparam int DW = 32, AW = 32, MB = 16, TMO = 16, RMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_burst_master_if #(.DW(DW), .AW(AW), .MAX_BURST(MB)) bus ();

  wb_burst_master #(.DW(DW), .AW(AW), .MAX_BURST(MB), .TIMEOUT(TMO), .RETRY_MAX(RMAX)) dut (
    .wb_clk (clk),
    .wb_rst (rst),
    .bus    (bus)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave / feeder knobs
  logic ack_en = 1'b1, err_ack = 1'b0;
  int   err_beat = -1, rty_beat = -1, rty_n = 0;
  int   nbeats = 0, gap_at = -1, gap_len = 0;
  logic [31:0] wdata [16];

  int sbeat = 0, rty_cnt = 0, widx = 0, gap_cnt = 0;

  always_comb begin
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_rty_i = 1'b0;
    if (bus.wb_cyc_o && bus.wb_stb_o) begin
      if (sbeat == err_beat) begin
        bus.wb_err_i = 1'b1;
        bus.wb_ack_i = err_ack;
      end else if (sbeat == rty_beat && rty_cnt < rty_n) bus.wb_rty_i = 1'b1;
      else bus.wb_ack_i = ack_en;
    end
  end
  assign bus.wb_dat_i = bus.wb_adr_o ^ 32'h5A5A_0000;
  assign bus.wr_valid = (widx < nbeats) && !(widx == gap_at && gap_cnt < gap_len);
  assign bus.wr_data  = wdata[widx[3:0]];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sbeat <= 0; rty_cnt <= 0; widx <= 0; gap_cnt <= 0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        sbeat <= 0; rty_cnt <= 0;
      end else if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_err_i) begin
        if (bus.wb_rty_i) rty_cnt <= rty_cnt + 1;
        else if (bus.wb_ack_i) sbeat <= sbeat + 1;
      end
      if (bus.resp_valid) begin
        widx <= 0; gap_cnt <= 0;
      end else begin
        if (bus.wr_valid && bus.wr_ready) widx <= widx + 1;
        if (widx == gap_at && gap_cnt < gap_len) gap_cnt <= gap_cnt + 1;
      end
    end
  end

  // monitor
  int cyc_no = 0, n_ack = 0, n_rd = 0, n_pop = 0, n_resp = 0, n_stb = 0;
  int n_stall = 0, n_gap = 0, n_rty = 0, ack_cyc = 0, rdy_cyc = 0;
  logic got_resp = 1'b0, rdy_seen = 1'b0;
  logic [1:0]  st = 2'b00;
  logic [31:0] stall_adr_first = '0, stall_adr_last = '0;
  logic [31:0] a_adr [16], a_dat [16], r_dat [16];
  logic [2:0]  a_cti [16];
  logic [3:0]  a_sel [16];
  logic        a_we  [16];
  logic [15:0] r_last = '0;

  always @(negedge clk) begin
    cyc_no++;
    if (!rst) begin
      if (bus.cmd_valid && bus.cmd_ready) begin
        n_ack = 0; n_rd = 0; n_pop = 0; n_resp = 0; n_stb = 0;
        n_stall = 0; n_gap = 0; n_rty = 0; got_resp = 1'b0; rdy_seen = 1'b0;
        r_last = '0;
      end
      if (bus.wb_cyc_o && bus.wb_stb_o) begin
        n_stb++;
        if (bus.wb_rty_i && !bus.wb_err_i) n_rty++;
        if (bus.wb_ack_i && !bus.wb_err_i && !bus.wb_rty_i && n_ack < 16) begin
          a_adr[n_ack] = bus.wb_adr_o;
          a_dat[n_ack] = bus.wb_dat_o;
          a_cti[n_ack] = bus.wb_cti_o;
          a_sel[n_ack] = bus.wb_sel_o;
          a_we[n_ack]  = bus.wb_we_o;
          ack_cyc = cyc_no;
          n_ack++;
        end
      end
      if (bus.wb_cyc_o && !bus.wb_stb_o) begin
        if (n_stall == 0) stall_adr_first = bus.wb_adr_o;
        stall_adr_last = bus.wb_adr_o;
        n_stall++;
      end
      if (!bus.wb_cyc_o && !bus.resp_valid && !bus.cmd_ready) n_gap++;
      if (bus.wr_valid && bus.wr_ready) n_pop++;
      if (bus.rd_valid && n_rd < 16) begin
        r_dat[n_rd] = bus.rd_data;
        r_last[n_rd] = bus.rd_last;
        n_rd++;
      end
      if (got_resp && !rdy_seen && bus.cmd_ready) begin
        rdy_cyc = cyc_no; rdy_seen = 1'b1;
      end
      if (bus.resp_valid) begin
        n_resp++; st = bus.resp_status; got_resp = 1'b1;
      end
    end
  end

  task automatic issue(input string tag, input logic [31:0] adr, input logic we,
                       input logic [3:0] sel, input logic [3:0] len);
    logic ok;
    ok = 1'b0;
    bus.cmd_adr = adr; bus.cmd_we = we; bus.cmd_sel = sel; bus.cmd_len = len;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    chk({tag, "_accept"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (n_resp != 0) break;
    end
    chk({tag, "_resp_seen"}, 64'(n_resp), 64'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  logic [31:0] e_adr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
  logic [2:0]  e_cti [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
  logic [31:0] e_rd  [4] = '{32'h5A5A0100, 32'h5A5A0104, 32'h5A5A0108, 32'h5A5A010C};
  logic [31:0] e_wr  [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_adr = '0; bus.cmd_we = 1'b0;
    bus.cmd_sel = '0; bus.cmd_len = '0;
    for (int i = 0; i < 16; i++) wdata[i] = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.cmd_ready,
                     bus.wr_ready, bus.rd_valid, bus.resp_valid}, 7'd0);
    chk("rst_adr", bus.wb_adr_o, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single write
    wdata[0] = 32'hDEADBEEF; nbeats = 1;
    issue("t1", 32'h9C000004, 1'b1, 4'hF, 4'd0);
    wait_resp("t1");
    chk("t1_nack", n_ack, 1);
    chk("t1_adr", a_adr[0], 32'h9C000004);
    chk("t1_cti", a_cti[0], 3'b000);
    chk("t1_we", a_we[0], 1'b1);
    chk("t1_sel", a_sel[0], 4'hF);
    chk("t1_dat", a_dat[0], 32'hDEADBEEF);
    chk("t1_pops", n_pop, 1);
    chk("t1_status", st, 2'b00);
    chk("t1_rdy_lat", rdy_cyc - ack_cyc, 2);

    // 2: read burst
    nbeats = 0;
    issue("t2", 32'h100, 1'b0, 4'hF, 4'd3);
    wait_resp("t2");
    chk("t2_nack", n_ack, 4);
    chk("t2_nrd", n_rd, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_adr%0d", i), a_adr[i], e_adr[i]);
      chk($sformatf("t2_cti%0d", i), a_cti[i], e_cti[i]);
      chk($sformatf("t2_rd%0d", i), r_dat[i], e_rd[i]);
    end
    chk("t2_last", r_last[3:0], 4'b1000);
    chk("t2_status", st, 2'b00);

    // 3: write burst with a 3-cycle wr_valid gap after the first beat
    for (int i = 0; i < 4; i++) wdata[i] = e_wr[i];
    nbeats = 4; gap_at = 1; gap_len = 3;
    issue("t3", 32'h100, 1'b1, 4'hF, 4'd3);
    wait_resp("t3");
    chk("t3_nstall", n_stall, 3);
    chk("t3_stall_adr0", stall_adr_first, 32'h104);
    chk("t3_stall_adr1", stall_adr_last, 32'h104);
    chk("t3_nack", n_ack, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_adr%0d", i), a_adr[i], e_adr[i]);
      chk($sformatf("t3_dat%0d", i), a_dat[i], e_wr[i]);
    end
    chk("t3_pops", n_pop, 4);
    chk("t3_status", st, 2'b00);
    gap_at = -1; gap_len = 0;

    // 4a: two rty on beat 2, tolerated
    nbeats = 0; rty_beat = 2; rty_n = 2;
    issue("t4a", 32'h100, 1'b0, 4'hF, 4'd3);
    wait_resp("t4a");
    chk("t4a_nrty", n_rty, 2);
    chk("t4a_gaps", n_gap, 2);
    chk("t4a_nack", n_ack, 4);
    chk("t4a_adr2", a_adr[2], 32'h108);
    chk("t4a_cti2", a_cti[2], 3'b010);
    chk("t4a_nrd", n_rd, 4);
    chk("t4a_status", st, 2'b00);

    // 4b: four rty on beat 2, abort
    rty_n = 4;
    issue("t4b", 32'h100, 1'b0, 4'hF, 4'd3);
    wait_resp("t4b");
    chk("t4b_nrty", n_rty, 4);
    chk("t4b_gaps", n_gap, 3);
    chk("t4b_nack", n_ack, 2);
    chk("t4b_nrd", n_rd, 2);
    chk("t4b_status", st, 2'b11);
    rty_beat = -1; rty_n = 0;

    // 5a: err on beat 1 of a 4-beat write, remaining beats drained
    nbeats = 4; err_beat = 1;
    issue("t5a", 32'h300, 1'b1, 4'hF, 4'd3);
    wait_resp("t5a");
    chk("t5a_nack", n_ack, 1);
    chk("t5a_nstb", n_stb, 2);
    chk("t5a_drain", n_gap, 2);
    chk("t5a_pops", n_pop, 4);
    chk("t5a_status", st, 2'b01);

    // 5b: err and ack together on a read
    nbeats = 0; err_beat = 0; err_ack = 1'b1;
    issue("t5b", 32'h400, 1'b0, 4'hF, 4'd1);
    wait_resp("t5b");
    chk("t5b_nrd", n_rd, 0);
    chk("t5b_nstb", n_stb, 1);
    chk("t5b_status", st, 2'b01);
    err_beat = -1; err_ack = 1'b0;

    // 6a: silent slave, timeout
    ack_en = 1'b0;
    issue("t6a", 32'h200, 1'b0, 4'hF, 4'd0);
    wait_resp("t6a");
    chk("t6a_nstb", n_stb, 16);
    chk("t6a_status", st, 2'b10);

    // 6b: reset in the middle of a burst
    issue("t6b", 32'h500, 1'b0, 4'hF, 4'd7);
    repeat (3) @(posedge clk);
    #1;
    chk("t6b_busy", bus.wb_cyc_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6b_ctrl", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.cmd_ready,
                     bus.wr_ready, bus.rd_valid, bus.resp_valid}, 7'd0);
    chk("t6b_adr", bus.wb_adr_o, 32'h0);
    chk("t6b_cti", bus.wb_cti_o, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ack_en = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("t6b_no_resp", n_resp, 0);

    // 7: recovery after reset
    issue("t7", 32'h100, 1'b0, 4'hF, 4'd0);
    wait_resp("t7");
    chk("t7_nrd", n_rd, 1);
    chk("t7_rd", r_dat[0], 32'h5A5A0100);
    chk("t7_last", r_last[0], 1'b1);
    chk("t7_cti", a_cti[0], 3'b000);
    chk("t7_status", st, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
